// File: rtl/ram_arbiter_if.sv
// Two-requester RAM access bundle shared by the arbiter and its clients.
// Each requester holds req with stable we/addr/wdata until its ack pulse.
interface ram_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one registered single-port RAM between two
// requesters; clears the whole RAM after reset before serving anyone.
module ram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    ram_arbiter_if.slave      bus,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              init_done
);
    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ACCESS,
        RESP,
        DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;
    logic              we_q;
    logic              a_ack_q;
    logic              b_ack_q;
    logic              init_done_q;
    logic              ptr_b_q;
    logic              win_b_q;
    logic              win_rd_q;
    logic              gnt_a;
    logic              gnt_b;

    // ptr_b_q set means B wins a tie
    assign gnt_a = bus.a_req && (!bus.b_req || !ptr_b_q);
    assign gnt_b = bus.b_req && !gnt_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            init_done_q <= 1'b0;
            ptr_b_q     <= 1'b0;
            win_b_q     <= 1'b0;
            win_rd_q    <= 1'b0;
        end else begin
            unique case (state_q)
                INIT: begin
                    we_q    <= 1'b1;
                    addr_q  <= cnt_q;
                    wdata_q <= '0;
                    cnt_q   <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        init_done_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                IDLE: begin
                    if (gnt_a || gnt_b) begin
                        we_q     <= gnt_a ? bus.a_we : bus.b_we;
                        addr_q   <= gnt_a ? bus.a_addr : bus.b_addr;
                        wdata_q  <= gnt_a ? bus.a_wdata : bus.b_wdata;
                        win_rd_q <= gnt_a ? !bus.a_we : !bus.b_we;
                        win_b_q  <= gnt_b;
                        ptr_b_q  <= gnt_a;
                        state_q  <= ACCESS;
                    end else begin
                        we_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    we_q    <= 1'b0;
                    state_q <= RESP;
                end
                RESP: begin
                    if (win_rd_q && win_b_q) b_rdata_q <= ram_rdata;
                    if (win_rd_q && !win_b_q) a_rdata_q <= ram_rdata;
                    a_ack_q <= !win_b_q;
                    b_ack_q <= win_b_q;
                    state_q <= DONE;
                end
                DONE: begin
                    a_ack_q <= 1'b0;
                    b_ack_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign ram_we      = we_q;
    assign ram_addr    = addr_q;
    assign ram_wdata   = wdata_q;
    assign init_done   = init_done_q;
    assign bus.a_ack   = a_ack_q;
    assign bus.b_ack   = b_ack_q;
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_rdata = b_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural registered RAM.
// Directed accesses push expected acks; a negedge monitor pops and checks.
module tb_ram_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       init_done;
    logic [7:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit       port_b;
        bit       rd;
        bit [7:0] data;
    } exp_t;

    exp_t sb[$];

    ram_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    // Registered read, old data on read-during-write
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.a_ack || bus.b_ack) begin
            exp_t e;
            check("single_ack", {bus.a_ack, bus.b_ack} == 2'b11, 0);
            if (sb.size() == 0) begin
                check("unexpected_ack", {bus.a_ack, bus.b_ack}, 0);
            end else begin
                e = sb.pop_front();
                check("ack_port", bus.b_ack, e.port_b);
                if (e.rd && e.port_b) check("b_rdata", bus.b_rdata, e.data);
                if (e.rd && !e.port_b) check("a_rdata", bus.a_rdata, e.data);
            end
        end
    end

    task automatic push(bit pb, bit rd, bit [7:0] d);
        exp_t e;
        e.port_b = pb;
        e.rd     = rd;
        e.data   = d;
        sb.push_back(e);
    endtask

    task automatic init_check();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("init_we", ram_we, 1);
            check("init_addr", ram_addr, i);
            check("init_wdata", ram_wdata, 0);
            check("init_done", init_done, i == 15);
        end
    endtask

    task automatic set_a(bit we, bit [3:0] ad, bit [7:0] wd);
        bus.a_req   = 1'b1;
        bus.a_we    = we;
        bus.a_addr  = ad;
        bus.a_wdata = wd;
    endtask

    task automatic set_b(bit we, bit [3:0] ad, bit [7:0] wd);
        bus.b_req   = 1'b1;
        bus.b_we    = we;
        bus.b_addr  = ad;
        bus.b_wdata = wd;
    endtask

    // Single access from IDLE; ack expected 3 edges after issue
    task automatic do_req(bit pb, bit we, bit [3:0] ad, bit [7:0] wd,
                          bit [7:0] exp_rd);
        int n = 0;
        push(pb, !we, exp_rd);
        if (pb) set_b(we, ad, wd);
        else    set_a(we, ad, wd);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((pb && bus.b_ack) || (!pb && bus.a_ack)) begin
                n = i + 1;
                break;
            end
        end
        check("ack_latency", n, 3);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        @(negedge clk);
    endtask

    // Both request together; scoreboard order holds the expected winner
    task automatic do_both(bit b_first);
        int served = 0;
        push(b_first, 1'b1, b_first ? 8'h00 : 8'hA5);
        push(!b_first, 1'b1, b_first ? 8'hA5 : 8'h00);
        set_a(1'b0, 4'h3, 8'h00);
        set_b(1'b0, 4'h9, 8'h00);
        for (int i = 0; i < 30 && served < 2; i++) begin
            @(negedge clk);
            if (bus.a_ack) begin bus.a_req = 1'b0; served++; end
            if (bus.b_ack) begin bus.b_req = 1'b0; served++; end
        end
        check("both_served", served, 2);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        rst = 1'b1;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

        // Request held across reset and INIT must be served first
        push(1'b0, 1'b0, 8'h00);
        set_a(1'b1, 4'h2, 8'h5A);
        repeat (3) @(negedge clk);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_done", init_done, 0);
        check("rst_acks", {bus.a_ack, bus.b_ack}, 0);
        check("rst_rdata", {bus.a_rdata, bus.b_rdata}, 0);
        rst = 1'b0;
        init_check();
        @(negedge clk);
        check("held_we", ram_we, 1);
        check("held_addr", ram_addr, 4'h2);
        check("held_wdata", ram_wdata, 8'h5A);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.a_ack) begin n = i + 1; break; end
        end
        check("held_latency", n, 2);
        bus.a_req = 1'b0;
        @(negedge clk);

        do_req(1'b0, 1'b1, 4'h3, 8'hA5, 8'h00);
        do_req(1'b0, 1'b0, 4'h3, 8'h00, 8'hA5);
        do_req(1'b0, 1'b0, 4'h2, 8'h00, 8'h5A);
        do_req(1'b1, 1'b0, 4'h9, 8'h00, 8'h00);

        // Pointer back at A: A,B then A,B
        do_both(1'b0);
        do_both(1'b0);
        // Serving A alone flips the pointer to B
        do_req(1'b0, 1'b1, 4'hC, 8'h3C, 8'h00);
        check("a_rdata_hold", bus.a_rdata, 8'hA5);
        do_both(1'b1);

        // Reset during ACCESS aborts B's write cycle
        set_b(1'b1, 4'h5, 8'h77);
        @(negedge clk);
        check("abort_grant_addr", ram_addr, 4'h5);
        rst = 1'b1;
        bus.b_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_ack", bus.b_ack, 0);
            check("abort_done", init_done, 0);
        end
        check("abort_rdata", {bus.a_rdata, bus.b_rdata}, 0);
        rst = 1'b0;
        init_check();
        @(negedge clk);
        do_req(1'b1, 1'b0, 4'h5, 8'h00, 8'h00);
        do_req(1'b0, 1'b0, 4'h3, 8'h00, 8'h00);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
